// File: rtl/cluster_tau_pkg.sv
// -----------------------------------------------------------------------------
// cluster_tau_pkg
// Shared definitions for the cluster_tau transmit-side driver.
//   TAU_WORDS    : number of upstream words that make up one cluster triple
//   TAU_WIDTH    : default bus width used by the typedefs below
//   tau_triple_t : one triple as launched onto input_0..input_2
//   tau_result_t : one result pair as captured from output_0/output_1
//   tau_next_idx : assembly counter step, 0 -> 1 -> 2 -> 0
// -----------------------------------------------------------------------------
package cluster_tau_pkg;

  localparam int TAU_WORDS = 3;
  localparam int TAU_WIDTH = 32;

  typedef struct packed {
    logic [TAU_WIDTH-1:0] word0;
    logic [TAU_WIDTH-1:0] word1;
    logic [TAU_WIDTH-1:0] word2;
  } tau_triple_t;

  typedef struct packed {
    logic [TAU_WIDTH-1:0] data0;
    logic [TAU_WIDTH-1:0] data1;
  } tau_result_t;

  function automatic logic [1:0] tau_next_idx(input logic [1:0] idx);
    return (idx == 2'(TAU_WORDS - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/cluster_tau_driver_fifo.sv
// -----------------------------------------------------------------------------
// tau_result_fifo
// Synchronous result FIFO, registered head (no fall-through).
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data at the tail this cycle
//   i_pop        : consume the head this cycle (ignored while empty)
//   o_pop_data   : head entry, forced to zero while empty
//   o_valid      : FIFO holds at least one entry
//   o_count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module tau_result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign o_valid    = (r_count != '0);
  assign w_pop      = i_pop && o_valid;
  // Gating the head keeps the output at zero after reset without clearing the array.
  assign o_pop_data = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;

  // NOTE: storage array has no reset; only pointers/count define what is valid,
  // which keeps the array mappable onto plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers are exactly PW bits wide, so the increment wraps on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The driver's credit scheme must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && (r_count == CW'(DEPTH)) && !w_pop));

endmodule

// File: rtl/cluster_tau_driver.sv
// -----------------------------------------------------------------------------
// cluster_tau_driver
// Assembles a word-serial upstream stream into triples, launches each triple
// onto the cluster inputs with a one-cycle strobe, captures the cluster result
// LATENCY cycles later and returns it on a valid/ready stream. Credits bound
// launched-plus-buffered results to RES_DEPTH so no result can be dropped.
//   clk, rst                    : clock, asynchronous active-high reset
//   s_data, s_valid, s_ready    : upstream word stream
//   input_0, input_1, input_2   : registered cluster inputs (held between launches)
//   launch                      : one-cycle pulse, first cycle of a new triple
//   output_0, output_1          : cluster results, sampled LATENCY cycles after launch
//   m_data0, m_data1, m_valid,
//   m_ready                     : result pair stream from the result FIFO head
// -----------------------------------------------------------------------------
module cluster_tau_driver
  import cluster_tau_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] input_0,
  output logic [WIDTH-1:0] input_1,
  output logic [WIDTH-1:0] input_2,
  output logic             launch,
  input  logic [WIDTH-1:0] output_0,
  input  logic [WIDTH-1:0] output_1,
  output logic [WIDTH-1:0] m_data0,
  output logic [WIDTH-1:0] m_data1,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int IW = $clog2(LATENCY + 1);
  localparam logic [1:0] LAST_IDX = 2'(TAU_WORDS - 1);

  logic [1:0]         r_idx;
  logic [WIDTH-1:0]   r_sh0;
  logic [WIDTH-1:0]   r_sh1;
  logic [WIDTH-1:0]   r_in0;
  logic [WIDTH-1:0]   r_in1;
  logic [WIDTH-1:0]   r_in2;
  logic               r_launch;
  logic [LATENCY-1:0] r_tok;
  logic [IW-1:0]      r_inflight;

  logic               w_last;
  logic               w_s_fire;
  logic               w_launch_next;
  logic               w_capture;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_credit;
  logic [2*WIDTH-1:0] w_head;
  logic               w_m_valid;

  // s_ready depends only on registered state: the assembly index and credit.
  assign w_last        = (r_idx == LAST_IDX);
  assign w_credit      = CW'(RES_DEPTH) - (CW'(r_inflight) + w_count);
  assign s_ready       = !w_last || (w_credit != '0);
  assign w_s_fire      = s_valid && s_ready;
  assign w_launch_next = w_s_fire && w_last;
  assign w_capture     = r_tok[LATENCY-1];

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_sh0 <= '0;
      r_sh1 <= '0;
    end else if (w_s_fire) begin
      if (r_idx == 2'd0) r_sh0 <= s_data;
      if (r_idx == 2'd1) r_sh1 <= s_data;
      r_idx <= tau_next_idx(r_idx);
    end
  end

  // Word 2 bypasses the shadow registers and goes straight to input_2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_launch <= 1'b0;
      r_in0    <= '0;
      r_in1    <= '0;
      r_in2    <= '0;
    end else begin
      r_launch <= w_launch_next;
      if (w_launch_next) begin
        r_in0 <= r_sh0;
        r_in1 <= r_sh1;
        r_in2 <= s_data;
      end
    end
  end

  // Token enters during the launch cycle and reaches the top bit in cycle
  // L+LATENCY, which is when the cluster outputs belong to that triple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tok      <= '0;
      r_inflight <= '0;
    end else begin
      r_tok <= (r_tok << 1) | LATENCY'(r_launch);
      case ({r_launch, w_capture})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  tau_result_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_capture),
    .i_push_data ({output_0, output_1}),
    .i_pop       (m_ready),
    .o_pop_data  (w_head),
    .o_valid     (w_m_valid),
    .o_count     (w_count)
  );

  assign input_0 = r_in0;
  assign input_1 = r_in1;
  assign input_2 = r_in2;
  assign launch  = r_launch;
  assign m_valid = w_m_valid;
  assign m_data0 = w_head[2*WIDTH-1:WIDTH];
  assign m_data1 = w_head[WIDTH-1:0];

endmodule

// File: tb/tb_cluster_tau_driver.sv
// -----------------------------------------------------------------------------
// tb_cluster_tau_driver
// Drives cluster_tau_driver with directed and randomized word streams. A small
// cluster model (output_0 = input_0 + input_1, output_1 = input_2, LATENCY
// stages deep) closes the loop. A queue-based reference tracks accepted words,
// expected launches and pending results, and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_cluster_tau_driver;
  import cluster_tau_pkg::*;

  localparam int WIDTH     = 32;
  localparam int LATENCY   = 2;
  localparam int RES_DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] input_0, input_1, input_2;
  logic             launch;
  logic [WIDTH-1:0] output_0, output_1;
  logic [WIDTH-1:0] m_data0, m_data1;
  logic             m_valid;
  logic             m_ready;

  cluster_tau_driver #(
    .WIDTH     (WIDTH),
    .LATENCY   (LATENCY),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .input_0  (input_0),
    .input_1  (input_1),
    .input_2  (input_2),
    .launch   (launch),
    .output_0 (output_0),
    .output_1 (output_1),
    .m_data0  (m_data0),
    .m_data1  (m_data1),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cluster stand-in: result valid LATENCY cycles after the launch cycle.
  logic [WIDTH-1:0] p0 [LATENCY];
  logic [WIDTH-1:0] p1 [LATENCY];
  always @(posedge clk) begin
    p0[0] <= input_0 + input_1;
    p1[0] <= input_2;
    for (int i = 1; i < LATENCY; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign output_0 = p0[LATENCY-1];
  assign output_1 = p1[LATENCY-1];

  // ---------------------------------------------------------------- checking
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------- reference model
  typedef struct {
    tau_result_t r;
    int          avail;   // first cycle the pair must be on m_valid
  } exp_res_t;

  logic [WIDTH-1:0] part_q [$];
  exp_res_t         res_q  [$];
  logic [WIDTH-1:0] exp_in0, exp_in1, exp_in2;
  logic             exp_launch;
  int               n_launch = 0;
  int               n_pop    = 0;
  int               n_stall  = 0;

  initial begin
    exp_res_t e;
    logic     exp_mv;
    exp_in0 = '0; exp_in1 = '0; exp_in2 = '0; exp_launch = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        part_q.delete();
        res_q.delete();
        exp_in0 = '0; exp_in1 = '0; exp_in2 = '0;
        exp_launch = 1'b0;
      end else begin
        // Outstanding results (launched or buffered) bound word-2 acceptance.
        check("s_ready", s_ready, (part_q.size() != 2) || (res_q.size() < RES_DEPTH));
        check("launch",  launch,  exp_launch);
        check("input_0", input_0, exp_in0);
        check("input_1", input_1, exp_in1);
        check("input_2", input_2, exp_in2);
        exp_mv = (res_q.size() > 0) && (res_q[0].avail <= cyc);
        check("m_valid", m_valid, exp_mv);
        if (exp_mv) begin
          check("m_data0", m_data0, res_q[0].r.data0);
          check("m_data1", m_data1, res_q[0].r.data1);
        end
        if (launch) n_launch++;
        // Apply the handshakes that complete at the coming rising edge.
        if (m_valid && m_ready && res_q.size() > 0) begin
          void'(res_q.pop_front());
          n_pop++;
        end
        exp_launch = 1'b0;
        if (s_valid && s_ready) begin
          part_q.push_back(s_data);
          if (part_q.size() == 3) begin
            exp_in0    = part_q[0];
            exp_in1    = part_q[1];
            exp_in2    = part_q[2];
            exp_launch = 1'b1;
            e.r.data0  = part_q[0] + part_q[1];
            e.r.data1  = part_q[2];
            e.avail    = cyc + 2 + LATENCY;
            res_q.push_back(e);
            part_q.delete();
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  int mr_mode = 1;   // 0: m_ready low, 1: high, 2: random
  bit gaps    = 1'b0;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (mr_mode == 2) ? 1'($urandom_range(0, 1)) : (mr_mode == 1);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc = -1;
    if (gaps) begin
      for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_data  = w;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end else begin
        n_stall++;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("word accepted in time", done, 1'b1);
  endtask

  task automatic send_triple(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c);
    int t;
    send_word(a, t);
    send_word(b, t);
    send_word(c, t);
  endtask

  initial begin
    int  t_acc;
    int  l0, p_0, st;
    bit  found;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    idle(3);
    rst = 1'b0;

    // Reset defaults.
    @(negedge clk);
    check("rst s_ready", s_ready, 1'b1);
    check("rst launch",  launch,  1'b0);
    check("rst m_valid", m_valid, 1'b0);
    check("rst input_0", input_0, 32'h0);
    @(posedge clk);
    #1;

    // Reset mid-operation: one result buffered plus a partial triple.
    mr_mode = 0;
    idle(1);
    send_triple(32'h7, 32'h8, 32'h9);
    send_word(32'h5, t_acc);
    found = 1'b0;
    for (int t = 0; t < 15 && !found; t++) begin
      @(negedge clk);
      found = m_valid;
    end
    check("buffered before reset", found, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    rst     = 1'b0;
    mr_mode = 1;
    @(negedge clk);
    check("mid-rst input_0", input_0, 32'h0);
    check("mid-rst input_1", input_1, 32'h0);
    check("mid-rst input_2", input_2, 32'h0);
    check("mid-rst launch",  launch,  1'b0);
    check("mid-rst m_valid", m_valid, 1'b0);
    check("mid-rst m_data0", m_data0, 32'h0);
    check("mid-rst m_data1", m_data1, 32'h0);
    check("mid-rst s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;
    send_triple(32'h1, 32'h2, 32'h3);
    @(negedge clk);
    check("first launch",   launch,  1'b1);
    check("first input_0",  input_0, 32'h1);
    check("first input_1",  input_1, 32'h2);
    check("first input_2",  input_2, 32'h3);
    @(negedge clk);
    check("launch one cycle", launch, 1'b0);
    @(posedge clk);
    #1;
    idle(8);

    // Latency: m_valid rises 4 cycles after word 2 with LATENCY=2.
    send_word(32'h10, t_acc);
    send_word(32'h20, t_acc);
    send_word(32'h30, t_acc);
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      found = m_valid;
    end
    check("latency cycles", cyc - t_acc, 4);
    check("latency m_data0", m_data0, 32'h30);
    check("latency m_data1", m_data1, 32'h30);
    @(posedge clk);
    #1;
    idle(4);

    // Backpressure and credit: 4 triples fit, word 2 of the 5th stalls.
    mr_mode = 0;
    idle(1);
    l0  = n_launch;
    p_0 = n_pop;
    for (int i = 0; i < 4; i++) send_triple($urandom, $urandom, $urandom);
    send_word($urandom, t_acc);
    send_word($urandom, t_acc);
    fork
      send_word($urandom, t_acc);
      begin
        repeat (8) @(negedge clk);
        check("credit stall s_ready", s_ready, 1'b0);
        check("launches while stalled", n_launch - l0, 4);
        mr_mode = 1;
        @(negedge clk);
        mr_mode = 0;
      end
    join
    idle(1);
    check("fifth launch", n_launch - l0, 5);
    mr_mode = 1;
    idle(12);
    check("backpressure results", n_pop - p_0, 5);

    // Full rate with m_ready high: no stalls, 100 results in order.
    st  = n_stall;
    p_0 = n_pop;
    for (int i = 0; i < 100; i++) send_triple($urandom, $urandom, $urandom);
    idle(10);
    check("full rate stalls", n_stall - st, 0);
    check("full rate results", n_pop - p_0, 100);

    // Upstream gaps with random m_ready, enough triples to wrap pointers.
    gaps    = 1'b1;
    mr_mode = 2;
    p_0     = n_pop;
    for (int i = 0; i < 3 * RES_DEPTH + 1 + 12; i++) send_triple($urandom, $urandom, $urandom);
    gaps    = 1'b0;
    mr_mode = 1;
    idle(20);
    check("random results", n_pop - p_0, 3 * RES_DEPTH + 1 + 12);
    check("scoreboard drained", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cluster_tau_driver.md
# cluster_tau_driver

Transmit-side companion for `cluster_tau`. It accepts a single-word upstream stream and assembles words into triples. Each triple is launched atomically onto the cluster's three input buses with a one-cycle `launch` strobe. After a fixed latency the block samples the cluster's two output buses and returns each result pair on a valid/ready result stream. It sits between a word-serial producer and the cluster, and provides credit-based flow control so that no result is ever dropped.

## Interface
Parameters:
- `WIDTH`, default 32: data width of every bus.
- `LATENCY`, default 2: cycles from the `launch` cycle to the cycle in which `output_0`/`output_1` are valid for that triple. Range 1..8.
- `RES_DEPTH`, default 4: result FIFO depth, and also the maximum number of triples in flight plus buffered. Must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `s_data`, in, WIDTH: upstream word.
- `s_valid`, in, 1: upstream word valid.
- `s_ready`, out, 1: driver accepts `s_data` this cycle.
- `input_0`, `input_1`, `input_2`, out, WIDTH: registered cluster inputs. They carry words 0, 1 and 2 of the current triple.
- `launch`, out, 1: one-cycle pulse in the first cycle a new triple is on `input_*`.
- `output_0`, `output_1`, in, WIDTH: cluster results, sampled internally.
- `m_data0`, `m_data1`, out, WIDTH: result pair, taken from the head of the result FIFO.
- `m_valid`, out, 1: a result pair is available.
- `m_ready`, in, 1: downstream accepts the pair.

## Operation
- **Handshake.** A transfer happens on a cycle where valid and ready are both high, on either stream. `s_valid` must not depend on `s_ready`.
- **Assembly counter `idx`.** Two bits, counting 0→1→2→0. Each accepted word is written to shadow register `sh[idx]`.
- **Credit.** `credit = RES_DEPTH − (inflight + fifo_count)`.
  - `inflight` counts launched triples not yet captured; its range is 0..LATENCY.
  - `s_ready = (idx != 2) || (credit != 0)`. Words 0 and 1 are therefore always accepted, and word 2 stalls until credit exists.
- **Launch.** When word 2 is accepted:
  - On the next edge, `input_0` takes `sh[0]`, `input_1` takes `sh[1]` and `input_2` takes `s_data`.
  - `launch` is asserted for that one cycle.
  - `idx` returns to 0.
  - `input_*` hold their values until the next launch.
- **Capture.** A LATENCY-deep shift register carries the launch token.
  - When the token reaches the end, the driver samples `output_0`/`output_1` into the FIFO tail.
  - That sample is taken at the edge closing cycle L+LATENCY, where L is the launch cycle.
- **Counter update.** `inflight` increments on launch and decrements on capture. A launch and a capture in the same cycle leave it unchanged.
- **FIFO simultaneous events.**
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - A push into an empty FIFO is visible on `m_valid` in the next cycle. There is no fall-through.
- **Overflow.** Overflow is impossible by construction of the credit rule. Assert this in simulation.
- **Pointers.** FIFO pointers are `$clog2(RES_DEPTH)` bits and wrap naturally.
- **Reset mid-operation.** Reset discards the partial triple, all in-flight tokens and all buffered results. The cluster is not reset by this block.

## Timing
- Reset values: `input_*` = 0, `launch` = 0, `m_valid` = 0, `m_data*` = 0, `idx` = 0, `inflight` = 0, FIFO empty.
- `s_ready` is 1 in the first cycle after reset.
- `s_ready` is combinational from registered state only; it has no path from `s_valid`.
- Word 2 accepted in cycle T:
  - `launch` = 1 in cycle T+1.
  - Capture occurs at the end of cycle T+1+LATENCY.
  - `m_valid` = 1 in cycle T+2+LATENCY.
- Minimum launch interval is 3 cycles, one per word. At full rate with `m_ready` held at 1, the driver never stalls.
- `m_data*` are stable while `m_valid` = 1 and `m_ready` = 0.

## Structure
- Package `cluster_tau_pkg`:
  - `localparam TAU_WORDS = 3`.
  - A typedef `tau_triple_t`, a packed struct of 3×WIDTH.
  - A typedef `tau_result_t`, a packed struct of 2×WIDTH.
  - Both typedefs are parameterised through the WIDTH default.
- One sub-module, `tau_result_fifo`:
  - Synchronous FIFO with parameters WIDTH=2×WIDTH and DEPTH=RES_DEPTH.
  - Exposes its count.
- The top level holds the assembly counter, the shadow registers, the token shift register and the credit logic.

## Test plan
- **Reset defaults.** Assert `rst` mid-sim with a partial triple and one result buffered → next cycle all outputs are 0 and `s_ready` = 1. Then send 0x1, 0x2, 0x3 → `input_0..2` = 1, 2, 3, with `launch` high for exactly one cycle.
- **Latency.** Model the cluster as `output_0` = `input_0` + `input_1` and `output_1` = `input_2`, with LATENCY=2. Send 0x10, 0x20, 0x30 → `m_valid` rises 4 cycles after word 2 is accepted, with `m_data0` = 0x30 and `m_data1` = 0x30.
- **Backpressure and credit.** Hold `m_ready` = 0 and stream 5 triples with RES_DEPTH=4 → 4 launches occur, and `s_ready` is low while word 2 of the 5th triple is offered. One `m_ready` pulse → the 5th triple launches, and nothing is lost.
- **Simultaneous push/pop.** Hold `m_ready` = 1 with continuous input → `fifo_count` never exceeds 1, `s_ready` stays 1, and 100 results are returned in order.
- **Upstream gaps.** Drive `s_valid` in a random 50% pattern → triples are still assembled in order, and `input_*` change only on `launch` cycles.
- **Pointer wrap.** Send 3×RES_DEPTH+1 triples with random `m_ready` → all results match the scoreboard, and the overflow assertion never fires.
